// File: rtl/i2d_core_defines.sv
// i2d_core_defines: shared core GPR constants and the write-back request type
package i2d_core_defines;
  localparam int NREG = 16;
  localparam int REG_AW = 4;
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [31:0]       data;
  } wb_req_t;
endpackage

// File: rtl/core_wb_fifo.sv
// core_wb_fifo: DEPTH-entry wb_req_t FIFO (clk, rst_n, push/din, pop/dout, full, empty); a push into a full FIFO lands only when it pops in the same cycle
module core_wb_fifo
  import i2d_core_defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/core_wb_arb.sv
// core_wb_arb: round-robin GPR write-back arbiter with per-source FIFOs and pending-write scoreboard (in: clk, rst_n, src_valid/addr/data, issue_set/addr; out: src_ready, wb/wb_addr/wb_data, busy, err)
module core_wb_arb
  import i2d_core_defines::*;
#(
  parameter int NSRC  = 3,
  parameter int DEPTH = 2,
  parameter int NREG  = i2d_core_defines::NREG
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NSRC-1:0]                src_valid,
  output logic [NSRC-1:0]                src_ready,
  input  logic [NSRC-1:0][REG_AW-1:0]    src_addr,
  input  logic [NSRC-1:0][31:0]          src_data,
  output logic                           wb,
  output logic [REG_AW-1:0]              wb_addr,
  output logic [31:0]                    wb_data,
  input  logic                           issue_set,
  input  logic [REG_AW-1:0]              issue_addr,
  output logic [NREG-1:0]                busy,
  output logic                           err
);
  localparam int SW = NSRC > 1 ? $clog2(NSRC) : 1;
  logic [SW-1:0] ptr, gnt, idx;
  logic gnt_vld;
  logic [NSRC-1:0] full, empty, pop, ovf;
  logic [NREG-1:0] set_v, clr_v;
  wb_req_t head [NSRC];
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign pop[i] = gnt_vld && gnt == SW'(i);
    assign ovf[i] = src_valid[i] && full[i] && !pop[i];
    core_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (src_valid[i]),
      .pop   (pop[i]),
      .din   (wb_req_t'{src_addr[i], src_data[i]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end
  assign src_ready = ~full;
  assign set_v = issue_set ? NREG'(1) << issue_addr : '0;
  assign clr_v = wb ? NREG'(1) << wb_addr : '0;
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = NSRC; k >= 1; k--) begin
      idx = SW'((int'(ptr) + k) % NSRC);
      gnt_vld = gnt_vld || !empty[idx];
      gnt = empty[idx] ? gnt : idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr     <= SW'(NSRC - 1);
      wb      <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      busy    <= '0;
      err     <= 1'b0;
    end else begin
      wb      <= gnt_vld;
      ptr     <= gnt_vld ? gnt : ptr;
      wb_addr <= gnt_vld ? head[gnt].addr : wb_addr;
      wb_data <= gnt_vld ? head[gnt].data : wb_data;
      busy    <= (busy & ~clr_v) | set_v;
      err     <= err | (|ovf) | (wb && !busy[wb_addr]);
    end
endmodule

// File: tb/tb_core_wb_arb.sv
// tb_core_wb_arb: scoreboard bench for core_wb_arb with a cycle model of the per-source queues
module tb_core_wb_arb;
  import i2d_core_defines::*;
  localparam int NSRC = 3;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic        wb;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] busy;
    logic        err;
    logic [2:0]  rdy;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] src_valid = '0;
  logic [2:0] src_ready;
  logic [2:0][3:0] src_addr = '0;
  logic [2:0][31:0] src_data = '0;
  logic wb;
  logic [3:0] wb_addr;
  logic [31:0] wb_data;
  logic issue_set = 1'b0;
  logic [3:0] issue_addr = '0;
  logic [15:0] busy;
  logic err;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q [$];
  logic [35:0] mq [NSRC][$];
  int mptr = NSRC - 1;
  logic mwb = 1'b0;
  logic [3:0] maddr = '0;
  logic [31:0] mdata = '0;
  logic [15:0] mbusy = '0;
  logic merr = 1'b0;
  core_wb_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .wb         (wb),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .issue_set  (issue_set),
    .issue_addr (issue_addr),
    .busy       (busy),
    .err        (err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  always @(posedge clk)
    if (rst_n) begin : model
      logic [15:0] nb;
      int g;
      exp_t e;
      nb = mbusy;
      if (mwb) nb[maddr] = 1'b0;
      if (issue_set) nb[issue_addr] = 1'b1;
      if (mwb && !mbusy[maddr]) merr = 1'b1;
      g = -1;
      for (int k = 1; k <= NSRC && g < 0; k++)
        if (mq[(mptr + k) % NSRC].size() > 0) g = (mptr + k) % NSRC;
      mwb = g >= 0;
      if (g >= 0) begin
        {maddr, mdata} = mq[g].pop_front();
        mptr = g;
      end
      for (int i = 0; i < NSRC; i++)
        if (src_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({src_addr[i], src_data[i]});
          else merr = 1'b1;
        end
      mbusy = nb;
      e.wb = mwb;
      e.addr = maddr;
      e.data = mdata;
      e.busy = mbusy;
      e.err = merr;
      for (int i = 0; i < NSRC; i++) e.rdy[i] = mq[i].size() < DEPTH;
      exp_q.push_back(e);
    end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{wb: 1'b0, addr: 4'h0, data: 32'h0, busy: 16'h0, err: 1'b0, rdy: 3'b111};
    chk("wb", wb, e.wb);
    chk("wb_addr", wb_addr, e.addr);
    chk("wb_data", wb_data, e.data);
    chk("busy", busy, e.busy);
    chk("err", err, e.err);
    chk("src_ready", src_ready, e.rdy);
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    mptr = NSRC - 1;
    mwb = 1'b0;
    maddr = '0;
    mdata = '0;
    mbusy = '0;
    merr = 1'b0;
    #1;
    chk("rst_wb", wb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", src_ready, 3'b111);
    tick;
    rst_n = 1'b1;
  endtask
  task automatic issue(input logic [3:0] r);
    issue_set = 1'b1;
    issue_addr = r;
    tick;
    issue_set = 1'b0;
  endtask
  initial begin
    int run [2];
    int maxrun;
    int mn;
    int ln;
    logic saw_full;
    logic [3:0] gsrc [$];
    #2 do_reset;
    issue(4'd3);
    src_valid = 3'b001;
    src_addr[0] = 4'd3;
    src_data[0] = 32'hDEADBEEF;
    tick;
    src_valid = '0;
    tick;
    chk("single_wb", wb, 1);
    chk("single_addr", wb_addr, 3);
    chk("single_data", wb_data, 32'hDEADBEEF);
    chk("single_busy_held", busy[3], 1);
    tick;
    chk("single_wb_off", wb, 0);
    chk("single_busy_clr", busy[3], 0);
    chk("single_err", err, 0);
    do_reset;
    for (int r = 1; r <= 6; r++) issue(4'(r));
    src_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      src_addr[i] = 4'(i + 1);
      src_data[i] = 32'hC0 + i;
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      src_addr[i] = 4'(i + 4);
      src_data[i] = 32'hD0 + i;
    end
    tick;
    src_valid = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      chk("cont_wb", wb, 1);
      chk("cont_addr", wb_addr, k + 1);
    end
    tick;
    chk("cont_idle", wb, 0);
    chk("cont_err", err, 0);
    do_reset;
    run[0] = 0;
    run[1] = 0;
    maxrun = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++) begin
        src_valid[i] = src_ready[i];
        src_addr[i] = 4'(c);
        src_data[i] = {4'(i), 28'(c)};
      end
      tick;
      for (int i = 0; i < 2; i++) begin
        run[i] = src_ready[i] ? 0 : run[i] + 1;
        if (run[i] > maxrun) maxrun = run[i];
      end
      if (wb) gsrc.push_back(wb_data[31:28]);
    end
    src_valid = '0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (wb) gsrc.push_back(wb_data[31:28]);
    end
    for (int k = 0; k < 8; k++) chk("rr_src", k < gsrc.size() ? gsrc[k] : 4'hF, k % 2);
    chk("rr_ready_run", maxrun, 1);
    do_reset;
    for (int r = 8; r <= 15; r++) issue(4'(r));
    mn = 0;
    ln = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 14; c++) begin
      src_valid[2] = src_ready[2] && mn < 5;
      src_addr[2] = 4'(8 + mn);
      src_data[2] = 32'h2000 + mn;
      src_valid[1] = c >= 1 && src_ready[1] && ln < 3;
      src_addr[1] = 4'(13 + ln);
      src_data[1] = 32'h1000 + ln;
      tick;
      mn += int'(src_valid[2]);
      ln += int'(src_valid[1]);
      if (!src_ready[1]) saw_full = 1'b1;
    end
    src_valid = '0;
    tick;
    chk("bp_full_seen", saw_full, 1);
    chk("bp_ready_back", src_ready[1], 1);
    chk("bp_err", err, 0);
    do_reset;
    issue(4'd7);
    chk("sb_busy_set", busy[7], 1);
    src_valid = 3'b001;
    src_addr[0] = 4'd7;
    src_data[0] = 32'h77;
    tick;
    src_valid = '0;
    tick;
    chk("sb_wb", wb, 1);
    chk("sb_busy_pending", busy[7], 1);
    issue(4'd7);
    chk("sb_set_wins", busy[7], 1);
    chk("sb_err", err, 0);
    src_valid = 3'b001;
    src_data[0] = 32'h78;
    tick;
    src_valid = '0;
    tick;
    tick;
    chk("sb_clear", busy[7], 0);
    chk("sb_err_after", err, 0);
    src_valid = 3'b001;
    src_addr[0] = 4'd9;
    src_data[0] = 32'h99;
    tick;
    src_valid = '0;
    tick;
    tick;
    chk("err_nonbusy", err, 1);
    tick;
    chk("err_sticky", err, 1);
    issue(4'd5);
    src_valid = 3'b011;
    src_addr[0] = 4'd1;
    src_addr[1] = 4'd2;
    tick;
    src_valid = '0;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("post_rst_wb", wb, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
